// File: rtl/gpio_led_key.sv
// Bus-mapped LED register plus debounced, edge-capturing push-button inputs.
// Define GPIO_KEY_IRQ_EN to add the IRQ_MASK register (addr 4) and the key-press interrupt.
module gpio_led_key #(
    parameter int LED_WIDTH       = 6,
    parameter int KEY_WIDTH       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 we,
    input  logic [2:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [LED_WIDTH-1:0] led,
    output logic                 irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 accept;
    logic                 wr_en;
    logic [KEY_WIDTH-1:0] sync1;
    logic [KEY_WIDTH-1:0] sync2;
    logic [KEY_WIDTH-1:0] stable;
    logic [KEY_WIDTH-1:0] key_edge;
    logic [KEY_WIDTH-1:0] press;
    logic [CNT_W-1:0]     cnt [KEY_WIDTH];
    logic [31:0]          read_mux;
    logic                 unused_ok;

`ifdef GPIO_KEY_IRQ_EN
    logic [KEY_WIDTH-1:0] mask;
`endif

    // A request is taken only while ready is low, so back-to-back ready pulses cannot occur.
    assign accept    = sel & ~ready;
    assign wr_en     = accept & we;
    assign unused_ok = &{1'b0, wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= accept;
            rdata <= (accept && !we) ? read_mux : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (wr_en) begin
            case (addr)
                3'd0:    led <= wdata[LED_WIDTH-1:0];
                3'd1:    led <= led ^ wdata[LED_WIDTH-1:0];
                default: led <= led;
            endcase
        end
    end

    // Keys are active-low; invert here so every later stage works in "1 = pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            press[i] = sync2[i] & ~stable[i] & (cnt[i] == CNT_MAX);
        end
    end

    // A press landing on the same edge as a write-1-clear wins, so no press is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_edge <= '0;
        end else if (wr_en && addr == 3'd3) begin
            key_edge <= (key_edge & ~wdata[KEY_WIDTH-1:0]) | press;
        end else begin
            key_edge <= key_edge | press;
        end
    end

    always_comb begin
        read_mux = '0;
        case (addr)
            3'd0:    read_mux[LED_WIDTH-1:0] = led;
            3'd2:    read_mux[KEY_WIDTH-1:0] = stable;
            3'd3:    read_mux[KEY_WIDTH-1:0] = key_edge;
`ifdef GPIO_KEY_IRQ_EN
            3'd4:    read_mux[KEY_WIDTH-1:0] = mask;
`endif
            default: read_mux = '0;
        endcase
    end

`ifdef GPIO_KEY_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && addr == 3'd4) begin
                mask <= wdata[KEY_WIDTH-1:0];
            end
            irq <= |(key_edge & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_led_key.sv
// Randomised self-checking bench for gpio_led_key against a window-based debounce/register model.
// Works with or without GPIO_KEY_IRQ_EN defined.
module tb_gpio_led_key;
    localparam int LW = 6;
    localparam int KW = 1;
    localparam int DC = 4;

    logic          clk;
    logic          reset;
    logic          sel;
    logic          we;
    logic [2:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [KW-1:0] key;
    logic [LW-1:0] led;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: raw pressed history (bit k = sample k edges ago) and register images.
    logic [15:0]   hist;
    logic          stable_m;
    logic          edge_m;
    logic          mask_m;
    logic          irq_m;
    logic          clr_pending;
    logic          clr_mask;
    logic [LW-1:0] led_m;

    gpio_led_key #(
        .LED_WIDTH(LW),
        .KEY_WIDTH(KW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .key(key),
        .led(led),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        hist        = '0;
        stable_m    = 1'b0;
        edge_m      = 1'b0;
        mask_m      = 1'b0;
        irq_m       = 1'b0;
        clr_pending = 1'b0;
        clr_mask    = 1'b0;
        led_m       = '0;
    endtask

    // A key change is accepted once the synchronised value (raw delayed two edges)
    // has disagreed with the stable state for DC consecutive edges.
    task automatic model_step();
        logic all_diff;
        logic pressed_now;
        irq_m = edge_m & mask_m;
        hist  = {hist[14:0], ~key[0]};
        all_diff = 1'b1;
        for (int k = 2; k <= DC + 1; k++) begin
            if (hist[k] == stable_m) all_diff = 1'b0;
        end
        pressed_now = 1'b0;
        if (all_diff) begin
            stable_m    = ~stable_m;
            pressed_now = stable_m;
        end
        if (clr_pending) begin
            if (clr_mask) edge_m = 1'b0;
            clr_pending = 1'b0;
        end
        if (pressed_now) edge_m = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        checkOutput("led_track", 32'(led), 32'(led_m));
        checkOutput("irq_track", 32'(irq), 32'(irq_m));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] expected_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(led_m);
            3'd2:    return 32'(stable_m);
            3'd3:    return 32'(edge_m);
            3'd4:    return 32'(mask_m);
            default: return 32'd0;
        endcase
    endfunction

    // sel is held for a second edge while ready is high; that request must be ignored.
    task automatic bus_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        logic [31:0] exp_rd;
        exp_rd = expected_read(a);
        sel = 1'b1; we = w; addr = a; wdata = d;
        if (w && a == 3'd3) begin
            clr_pending = 1'b1;
            clr_mask    = d[0];
        end
        if (w && a == 3'd0) led_m = d[LW-1:0];
        if (w && a == 3'd1) led_m = led_m ^ d[LW-1:0];
        tick();
        checkOutput("ready_pulse", 32'(ready), 32'd1);
        rd = rdata;
        if (!w) checkOutput("rdata", rdata, exp_rd);
`ifdef GPIO_KEY_IRQ_EN
        if (w && a == 3'd4) mask_m = d[0];
`endif
        tick();
        checkOutput("ready_single", 32'(ready), 32'd0);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        ticks(2);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        #2 reset = 1'b0;
    endtask

    task automatic applyStimulus(input int n_ops);
        logic [31:0] rd;
        for (int i = 0; i < n_ops; i++) begin
            case ($urandom_range(0, 6))
                0: bus_access(1'b1, 3'd0, $urandom, rd);
                1: bus_access(1'b1, 3'd1, $urandom, rd);
                2: begin
                    key = 1'b0;
                    ticks($urandom_range(1, 7));
                    key = 1'b1;
                    ticks($urandom_range(0, 8));
                end
                3: bus_access(1'b0, 3'($urandom_range(0, 7)), $urandom, rd);
                4: bus_access(1'b1, 3'd3, $urandom, rd);
                5: bus_access(1'b1, 3'($urandom_range(4, 7)), $urandom, rd);
                default: begin
                    key = ~key;
                    ticks($urandom_range(1, 6));
                end
            endcase
        end
    endtask

    initial begin
        logic [31:0] rd;
        sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; key = 1'b1; reset = 1'b0;
        model_reset();
        do_reset();

        bus_access(1'b1, 3'd0, 32'h2A, rd);
        checkOutput("led_write", 32'(led), 32'h2A);
        bus_access(1'b0, 3'd0, 32'h0, rd);
        checkOutput("rd_led", rd, 32'h2A);

        bus_access(1'b1, 3'd1, 32'h3F, rd);
        checkOutput("led_toggle", 32'(led), 32'h15);
        bus_access(1'b0, 3'd1, 32'h0, rd);
        checkOutput("rd_toggle", rd, 32'h0);

        key = 1'b0; ticks(2); key = 1'b1; ticks(8);
        bus_access(1'b0, 3'd2, 32'h0, rd);
        checkOutput("glitch_state", rd, 32'h0);
        bus_access(1'b0, 3'd3, 32'h0, rd);
        checkOutput("glitch_edge", rd, 32'h0);

        key = 1'b0; ticks(6);
        bus_access(1'b0, 3'd2, 32'h0, rd);
        checkOutput("press_state", rd, 32'h1);
        bus_access(1'b0, 3'd3, 32'h0, rd);
        checkOutput("press_edge", rd, 32'h1);
        bus_access(1'b1, 3'd3, 32'h1, rd);
        bus_access(1'b0, 3'd3, 32'h0, rd);
        checkOutput("edge_clr", rd, 32'h0);

        bus_access(1'b1, 3'd4, 32'h1, rd);
        bus_access(1'b0, 3'd4, 32'h0, rd);
`ifdef GPIO_KEY_IRQ_EN
        checkOutput("mask_rd", rd, 32'h1);
`else
        checkOutput("mask_rd", rd, 32'h0);
`endif
        key = 1'b1; ticks(8);
        key = 1'b0; ticks(7);
`ifdef GPIO_KEY_IRQ_EN
        checkOutput("irq_set", 32'(irq), 32'h1);
`else
        checkOutput("irq_set", 32'(irq), 32'h0);
`endif
        bus_access(1'b1, 3'd3, 32'h1, rd);
        ticks(1);
        checkOutput("irq_clr", 32'(irq), 32'h0);

        key = 1'b1; ticks(8);
        key = 1'b0; ticks(5);
        bus_access(1'b1, 3'd3, 32'h1, rd);
        bus_access(1'b0, 3'd3, 32'h0, rd);
        checkOutput("press_beats_clr", rd, 32'h1);

        key = 1'b1; ticks(8);
        sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h3F;
        #2 reset = 1'b1;
        model_reset();
        tick();
        checkOutput("abort_ready", 32'(ready), 32'd0);
        checkOutput("abort_led", 32'(led), 32'd0);
        sel = 1'b0; we = 1'b0;
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_ready", 32'(ready), 32'd0);
        end
        bus_access(1'b0, 3'd3, 32'h0, rd);
        checkOutput("abort_edge", rd, 32'h0);

        applyStimulus(80);
        bus_access(1'b0, 3'd2, 32'h0, rd);
        bus_access(1'b0, 3'd3, 32'h0, rd);
        bus_access(1'b0, 3'd0, 32'h0, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
